// File: rtl/draw_board_pkg.sv
// Shared types and constants for the battleship board renderer:
// cell encodings, palette and default board geometry.
package draw_board_pkg;

    localparam int BOARD_X = 64;
    localparam int BOARD_Y = 96;
    localparam int GRID_N  = 10;

    typedef enum logic [1:0] {
        WATER = 2'b00,
        SHIP  = 2'b01,
        MISS  = 2'b10,
        HIT   = 2'b11
    } cell_state_t;

    localparam logic [11:0] COL_WATER  = 12'h36A;
    localparam logic [11:0] COL_SHIP   = 12'h888;
    localparam logic [11:0] COL_MISS   = 12'hCCC;
    localparam logic [11:0] COL_HIT    = 12'hF00;
    localparam logic [11:0] COL_GRID   = 12'h000;
    localparam logic [11:0] COL_CURSOR = 12'hFF0;

    function automatic logic [11:0] cell_colour(input cell_state_t s);
        logic [11:0] c;
        c = COL_WATER;
        case (s)
            WATER: c = COL_WATER;
            SHIP:  c = COL_SHIP;
            MISS:  c = COL_MISS;
            HIT:   c = COL_HIT;
            default: c = COL_WATER;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/draw_board_blink.sv
// Frame-based blink generator: toggles blink_phase every BLINK_FRAMES
// rising edges of vsync. Usable for any blinking marker.
module board_blink #(
    parameter int BLINK_FRAMES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic blink_phase
);
    import draw_board_pkg::*;

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic          vsync_prev;
    logic          vsync_rise;
    logic [CW-1:0] frame_cnt;

    assign vsync_rise = vsync && !vsync_prev;

    // The phase starts visible so a freshly reset cursor shows immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_prev  <= 1'b0;
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            vsync_prev <= vsync;
            if (vsync_rise) begin
                if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= !blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/draw_board.sv
// Overlays the 10x10 battleship board (cells, grid lines, blinking cursor
// frame) onto the VGA stream with a fixed 2-clock latency.
module draw_board #(
    parameter int BOARD_X      = draw_board_pkg::BOARD_X,
    parameter int BOARD_Y      = draw_board_pkg::BOARD_Y,
    parameter int CELL_LOG2    = 5,
    parameter int GRID_N       = draw_board_pkg::GRID_N,
    parameter int BLINK_FRAMES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] vga_in_vcount,
    input  logic        vga_in_vsync,
    input  logic        vga_in_vblnk,
    input  logic [10:0] vga_in_hcount,
    input  logic        vga_in_hsync,
    input  logic        vga_in_hblnk,
    input  logic [11:0] vga_in_rgb,
    output logic [10:0] vga_out_vcount,
    output logic        vga_out_vsync,
    output logic        vga_out_vblnk,
    output logic [10:0] vga_out_hcount,
    output logic        vga_out_hsync,
    output logic        vga_out_hblnk,
    output logic [11:0] vga_out_rgb,
    output logic [6:0]  cell_addr,
    input  logic [1:0]  cell_state,
    input  logic [3:0]  cursor_x,
    input  logic [3:0]  cursor_y,
    input  logic        cursor_en
);
    import draw_board_pkg::*;

    localparam int CW      = 11 - CELL_LOG2;
    localparam int CELL    = 1 << CELL_LOG2;
    localparam int BOARD_W = GRID_N << CELL_LOG2;

    logic [10:0]          dx, dy;
    logic [CW-1:0]        col, row;
    logic [CELL_LOG2-1:0] ox, oy;
    logic                 in_board_nxt, cell_valid_nxt, grid_nxt, near_edge, cursor_nxt;
    logic [6:0]           addr_nxt;

    logic        s1_in_board, s1_grid, s1_cursor, s1_valid;
    logic [10:0] s1_vcount, s1_hcount;
    logic        s1_vsync, s1_vblnk, s1_hsync, s1_hblnk;
    logic [11:0] s1_rgb;
    logic [11:0] rgb_nxt;
    logic        blink_phase;

    // The board range is inclusive at the far edge so the closing grid line
    // (col/row == GRID_N) is still drawn even though it has no cell behind it.
    always_comb begin
        dx             = vga_in_hcount - 11'(BOARD_X);
        dy             = vga_in_vcount - 11'(BOARD_Y);
        col            = dx[10:CELL_LOG2];
        row            = dy[10:CELL_LOG2];
        ox             = dx[CELL_LOG2-1:0];
        oy             = dy[CELL_LOG2-1:0];
        in_board_nxt   = (vga_in_hcount >= 11'(BOARD_X)) && (vga_in_hcount <= 11'(BOARD_X + BOARD_W))
                      && (vga_in_vcount >= 11'(BOARD_Y)) && (vga_in_vcount <= 11'(BOARD_Y + BOARD_W));
        cell_valid_nxt = in_board_nxt && (int'(col) < GRID_N) && (int'(row) < GRID_N);
        addr_nxt       = cell_valid_nxt ? 7'(int'(row) * GRID_N + int'(col)) : 7'd0;
        grid_nxt       = (ox == '0) || (oy == '0);
        near_edge      = (int'(ox) <= 2) || (int'(ox) >= CELL - 2)
                      || (int'(oy) <= 2) || (int'(oy) >= CELL - 2);
        cursor_nxt     = cell_valid_nxt && !grid_nxt && near_edge
                      && (int'(cursor_x) < GRID_N) && (int'(cursor_y) < GRID_N)
                      && (int'(col) == int'(cursor_x)) && (int'(row) == int'(cursor_y));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_in_board <= 1'b0;
            s1_grid     <= 1'b0;
            s1_cursor   <= 1'b0;
            s1_valid    <= 1'b0;
            s1_vcount   <= '0;
            s1_vsync    <= 1'b0;
            s1_vblnk    <= 1'b0;
            s1_hcount   <= '0;
            s1_hsync    <= 1'b0;
            s1_hblnk    <= 1'b0;
            s1_rgb      <= '0;
            cell_addr   <= '0;
        end else begin
            s1_in_board <= in_board_nxt;
            s1_grid     <= grid_nxt;
            s1_cursor   <= cursor_nxt;
            s1_valid    <= cell_valid_nxt;
            s1_vcount   <= vga_in_vcount;
            s1_vsync    <= vga_in_vsync;
            s1_vblnk    <= vga_in_vblnk;
            s1_hcount   <= vga_in_hcount;
            s1_hsync    <= vga_in_hsync;
            s1_hblnk    <= vga_in_hblnk;
            s1_rgb      <= vga_in_rgb;
            cell_addr   <= addr_nxt;
        end
    end

    board_blink #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vga_in_vsync),
        .blink_phase(blink_phase)
    );

    // Colour priority: blanking, outside board, grid, cursor frame, cell fill.
    always_comb begin
        rgb_nxt = s1_rgb;
        if (s1_hblnk || s1_vblnk) begin
            rgb_nxt = s1_rgb;
        end else if (!s1_in_board) begin
            rgb_nxt = s1_rgb;
        end else if (s1_grid) begin
            rgb_nxt = COL_GRID;
        end else if (s1_cursor && cursor_en && blink_phase) begin
            rgb_nxt = COL_CURSOR;
        end else if (!s1_valid) begin
            rgb_nxt = s1_rgb;
        end else begin
            rgb_nxt = cell_colour(cell_state_t'(cell_state));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_out_vcount <= '0;
            vga_out_vsync  <= 1'b0;
            vga_out_vblnk  <= 1'b0;
            vga_out_hcount <= '0;
            vga_out_hsync  <= 1'b0;
            vga_out_hblnk  <= 1'b0;
            vga_out_rgb    <= '0;
        end else begin
            vga_out_vcount <= s1_vcount;
            vga_out_vsync  <= s1_vsync;
            vga_out_vblnk  <= s1_vblnk;
            vga_out_hcount <= s1_hcount;
            vga_out_hsync  <= s1_hsync;
            vga_out_hblnk  <= s1_hblnk;
            vga_out_rgb    <= rgb_nxt;
        end
    end

endmodule

// File: tb/tb_draw_board.sv
// Randomized self-checking bench for draw_board against a pixel-rule
// reference model and a synchronous board RAM model.
module tb_draw_board;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] vga_in_vcount, vga_in_hcount;
    logic        vga_in_vsync, vga_in_vblnk, vga_in_hsync, vga_in_hblnk;
    logic [11:0] vga_in_rgb;
    logic [10:0] vga_out_vcount, vga_out_hcount;
    logic        vga_out_vsync, vga_out_vblnk, vga_out_hsync, vga_out_hblnk;
    logic [11:0] vga_out_rgb;
    logic [6:0]  cell_addr;
    logic [1:0]  cell_state;
    logic [3:0]  cursor_x, cursor_y;
    logic        cursor_en;

    logic [1:0]  ram [100];
    logic [11:0] palette [4];
    int          vsync_edges;
    int          n_checks;
    int          n_fails;
    logic [25:0] out_timing;

    assign out_timing = {vga_out_vcount, vga_out_vsync, vga_out_vblnk,
                         vga_out_hcount, vga_out_hsync, vga_out_hblnk};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cell_addr < 7'd100) cell_state <= ram[cell_addr];
        else                    cell_state <= 2'b00;
    end

    draw_board dut (
        .clk(clk), .rst(rst),
        .vga_in_vcount(vga_in_vcount), .vga_in_vsync(vga_in_vsync), .vga_in_vblnk(vga_in_vblnk),
        .vga_in_hcount(vga_in_hcount), .vga_in_hsync(vga_in_hsync), .vga_in_hblnk(vga_in_hblnk),
        .vga_in_rgb(vga_in_rgb),
        .vga_out_vcount(vga_out_vcount), .vga_out_vsync(vga_out_vsync), .vga_out_vblnk(vga_out_vblnk),
        .vga_out_hcount(vga_out_hcount), .vga_out_hsync(vga_out_hsync), .vga_out_hblnk(vga_out_hblnk),
        .vga_out_rgb(vga_out_rgb),
        .cell_addr(cell_addr), .cell_state(cell_state),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds one pixel for three clocks so the RAM read has settled.
    task automatic drive_pixel(input int x, input int y, input bit hb, input bit vb, input logic [11:0] rgb);
        vga_in_hcount = 11'(x);
        vga_in_vcount = 11'(y);
        vga_in_hblnk  = hb;
        vga_in_vblnk  = vb;
        vga_in_hsync  = 1'($urandom % 2);
        vga_in_vsync  = 1'b0;
        vga_in_rgb    = rgb;
        repeat (3) tick();
    endtask

    task automatic pulse_vsync();
        vga_in_vsync = 1'b1;
        tick();
        vga_in_vsync = 1'b0;
        tick();
        vsync_edges++;
    endtask

    function automatic int model_addr(input int x, input int y);
        int dx, dy;
        dx = x - 64;
        dy = y - 96;
        if (dx < 0 || dy < 0 || dx >= 320 || dy >= 320) return 0;
        return (dy / 32) * 10 + (dx / 32);
    endfunction

    function automatic logic [11:0] model_rgb(input int x, input int y, input bit hb, input bit vb,
                                              input logic [11:0] rin);
        int  dx, dy, col, row, ox, oy;
        bit  phase;
        if (hb || vb) return rin;
        if (x < 64 || x > 384 || y < 96 || y > 416) return rin;
        dx = x - 64;  dy = y - 96;
        ox = dx % 32; oy = dy % 32;
        col = dx / 32; row = dy / 32;
        if (ox == 0 || oy == 0) return 12'h000;
        phase = ((vsync_edges / 16) % 2) == 0;
        if (cursor_en && phase && cursor_x < 10 && cursor_y < 10 && col == int'(cursor_x)
            && row == int'(cursor_y) && (ox <= 2 || ox >= 30 || oy <= 2 || oy >= 30))
            return 12'hFF0;
        if (col >= 10 || row >= 10) return rin;
        return palette[ram[row * 10 + col]];
    endfunction

    task automatic test_reset();
        logic [25:0] hist_t [16];
        int          hx [16];
        int          hy [16];
        logic [25:0] stim;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vga_in_hcount = 11'($urandom_range(1023, 0));
            vga_in_vcount = 11'($urandom_range(767, 0));
            vga_in_rgb    = 12'($urandom);
            vga_in_hsync  = 1'($urandom % 2);
            tick();
            n_checks++;
            if ({out_timing, vga_out_rgb} !== 38'd0 || cell_addr !== 7'd0) begin
                n_fails++;
                $display("[TB] FAIL reset_state: got vga_out=%h cell_addr=%0d expected all zero",
                         {out_timing, vga_out_rgb}, cell_addr);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            hx[i] = $urandom_range(500, 0);
            hy[i] = $urandom_range(500, 0);
            stim  = {11'(hy[i]), 1'b0, 1'($urandom % 2), 11'(hx[i]), 1'($urandom % 2), 1'($urandom % 2)};
            hist_t[i] = stim;
            {vga_in_vcount, vga_in_vsync, vga_in_vblnk, vga_in_hcount, vga_in_hsync, vga_in_hblnk} = stim;
            vga_in_rgb = 12'($urandom);
            tick();
            n_checks++;
            if (int'(cell_addr) !== model_addr(hx[i], hy[i])) begin
                n_fails++;
                $display("[TB] FAIL addr_latency: got %0d expected %0d", cell_addr, model_addr(hx[i], hy[i]));
            end
            if (i >= 1) begin
                n_checks++;
                if (out_timing !== hist_t[i-1]) begin
                    n_fails++;
                    $display("[TB] FAIL timing_delay: got %h expected %h", out_timing, hist_t[i-1]);
                end
            end
        end
    endtask

    task automatic test_cell_colour();
        int x, y; bit hb, vb; logic [11:0] rin, exp;
        cursor_en = 1'b0;
        drive_pixel(64 + 3*32 + 10, 96 + 2*32 + 10, 1'b0, 1'b0, 12'h0A5);
        n_checks++;
        if (cell_addr !== 7'd23 || vga_out_rgb !== 12'hF00) begin
            n_fails++;
            $display("[TB] FAIL hit_cell: got addr=%0d rgb=%h expected addr=23 rgb=f00", cell_addr, vga_out_rgb);
        end
        for (int i = 0; i < 40; i++) begin
            x = $urandom_range(420, 40);  y = $urandom_range(440, 80);
            hb = ($urandom % 8) == 0;     vb = ($urandom % 8) == 0;
            rin = 12'($urandom);
            drive_pixel(x, y, hb, vb, rin);
            exp = model_rgb(x, y, hb, vb, rin);
            n_checks++;
            if (vga_out_rgb !== exp || (!hb && !vb && int'(cell_addr) !== model_addr(x, y))) begin
                n_fails++;
                $display("[TB] FAIL random_pixel (%0d,%0d): got rgb=%h addr=%0d expected rgb=%h addr=%0d",
                         x, y, vga_out_rgb, cell_addr, exp, model_addr(x, y));
            end
        end
    endtask

    task automatic test_grid();
        int gx [6] = '{64+64, 64+320, 64+321, 64, 64+100, 63};
        int gy [6] = '{96+5,  96+5,   96+40,  96+100, 96+320, 150};
        logic [11:0] rin, exp;
        for (int i = 0; i < 6; i++) begin
            rin = 12'($urandom);
            drive_pixel(gx[i], gy[i], 1'b0, 1'b0, rin);
            exp = (i == 2 || i == 5) ? rin : 12'h000;
            n_checks++;
            if (vga_out_rgb !== exp) begin
                n_fails++;
                $display("[TB] FAIL grid_%0d: got %h expected %h", i, vga_out_rgb, exp);
            end
        end
    endtask

    task automatic test_cursor();
        int x, y; logic [11:0] rin, exp;
        cursor_x = 4'd4; cursor_y = 4'd7; cursor_en = 1'b1;
        drive_pixel(64 + 4*32 + 1, 96 + 7*32 + 16, 1'b0, 1'b0, 12'h123);
        n_checks++;
        if (vga_out_rgb !== 12'hFF0) begin
            n_fails++;
            $display("[TB] FAIL cursor_border: got %h expected ff0", vga_out_rgb);
        end
        drive_pixel(64 + 4*32 + 16, 96 + 7*32 + 16, 1'b0, 1'b0, 12'h123);
        n_checks++;
        if (vga_out_rgb !== palette[ram[74]]) begin
            n_fails++;
            $display("[TB] FAIL cursor_centre: got %h expected %h", vga_out_rgb, palette[ram[74]]);
        end
        for (int i = 0; i < 40; i++) begin
            cursor_x = 4'($urandom_range(11, 0));
            cursor_y = 4'($urandom_range(11, 0));
            x = 64 + int'(cursor_x) * 32 + $urandom_range(33, 0);
            y = 96 + int'(cursor_y) * 32 + $urandom_range(33, 0);
            rin = 12'($urandom);
            drive_pixel(x, y, 1'b0, 1'b0, rin);
            exp = model_rgb(x, y, 1'b0, 1'b0, rin);
            n_checks++;
            if (vga_out_rgb !== exp) begin
                n_fails++;
                $display("[TB] FAIL cursor_random (%0d,%0d) cur=(%0d,%0d): got %h expected %h",
                         x, y, cursor_x, cursor_y, vga_out_rgb, exp);
            end
        end
    endtask

    task automatic test_blink();
        int bx, by, x, y; logic [11:0] exp, rin;
        int after [4] = '{15, 16, 31, 32};
        cursor_x = 4'd4; cursor_y = 4'd7; cursor_en = 1'b1;
        bx = 64 + 4*32 + 30; by = 96 + 7*32 + 10;
        for (int k = 0; k < 4; k++) begin
            while (vsync_edges < after[k]) pulse_vsync();
            drive_pixel(bx, by, 1'b0, 1'b0, 12'h456);
            exp = (k == 1 || k == 2) ? palette[ram[74]] : 12'hFF0;
            n_checks++;
            if (vga_out_rgb !== exp) begin
                n_fails++;
                $display("[TB] FAIL blink_after_%0d: got %h expected %h", after[k], vga_out_rgb, exp);
            end
        end
        cursor_x = 4'd12;
        for (int i = 0; i < 12; i++) begin
            x = $urandom_range(400, 60); y = 96 + 7*32 + $urandom_range(32, 0);
            rin = 12'($urandom_range(4095, 0));
            if (rin == 12'hFF0) rin = 12'h0FF;
            drive_pixel(x, y, 1'b0, 1'b0, rin);
            exp = model_rgb(x, y, 1'b0, 1'b0, rin);
            n_checks++;
            if (vga_out_rgb !== exp || vga_out_rgb === 12'hFF0) begin
                n_fails++;
                $display("[TB] FAIL cursor_out_of_range (%0d,%0d): got %h expected %h", x, y, vga_out_rgb, exp);
            end
        end
        cursor_x = 4'd4; cursor_en = 1'b0;
        drive_pixel(bx, by, 1'b0, 1'b0, 12'h456);
        n_checks++;
        if (vga_out_rgb !== palette[ram[74]]) begin
            n_fails++;
            $display("[TB] FAIL cursor_disabled: got %h expected %h", vga_out_rgb, palette[ram[74]]);
        end
    endtask

    task automatic test_blanking();
        int x, y; bit hb; logic [11:0] rin;
        cursor_x = 4'd2; cursor_y = 4'd2; cursor_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            x = $urandom_range(384, 64); y = $urandom_range(416, 96);
            hb = (i % 2) == 0;
            rin = 12'($urandom);
            drive_pixel(x, y, hb, !hb, rin);
            n_checks++;
            if (vga_out_rgb !== rin) begin
                n_fails++;
                $display("[TB] FAIL blank_passthrough (%0d,%0d): got %h expected %h", x, y, vga_out_rgb, rin);
            end
        end
    endtask

    initial begin
        n_checks = 0; n_fails = 0; vsync_edges = 0;
        palette[0] = 12'h36A; palette[1] = 12'h888; palette[2] = 12'hCCC; palette[3] = 12'hF00;
        for (int i = 0; i < 100; i++) ram[i] = 2'($urandom % 4);
        ram[23] = 2'b11;
        rst = 1'b1;
        vga_in_vsync = 1'b0; vga_in_vblnk = 1'b0; vga_in_hblnk = 1'b0; vga_in_hsync = 1'b0;
        vga_in_hcount = '0; vga_in_vcount = '0; vga_in_rgb = '0;
        cursor_x = 4'd0; cursor_y = 4'd0; cursor_en = 1'b0;
        test_reset();
        test_cell_colour();
        test_grid();
        test_cursor();
        test_blink();
        test_blanking();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
